// File: rtl/acc_delta_decoder.sv
// Recovers per-step increments from a stream of wrapped accumulator values.
// Each delta is the modulo-2^BUS_WIDTH difference between consecutive accepted samples, buffered in a small FIFO.
module acc_delta_decoder #(
    parameter int BUS_WIDTH = 4,
    parameter int DEPTH     = 4
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_clear,
    input  logic                     i_valid,
    input  logic [BUS_WIDTH-1:0]     i_acc,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [BUS_WIDTH-1:0]     o_delta,
    input  logic                     i_ready,
    output logic                     o_primed,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic {
        ST_UNPRIMED = 1'b0,
        ST_RUN      = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [BUS_WIDTH-1:0] prev_r;
    logic [BUS_WIDTH-1:0] prev_nxt_s;
    logic [BUS_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [PW:0]          count_r;
    logic                 accept_s;
    logic                 push_s;
    logic                 pop_s;
    logic [BUS_WIDTH-1:0] delta_s;

    assign o_ready  = (count_r < DEPTH_C);
    assign o_valid  = (count_r != {(PW+1){1'b0}});
    assign o_primed = (state_r == ST_RUN);
    assign o_count  = count_r;
    // Mask the head entry when empty so stale storage never leaks out.
    assign o_delta  = o_valid ? mem_r[rd_ptr_r] : {BUS_WIDTH{1'b0}};

    assign accept_s = i_valid & o_ready & ~i_clear;
    assign pop_s    = o_valid & i_ready & ~i_clear;
    assign delta_s  = i_acc - prev_r;

    // Next-state logic: first accepted sample primes, later ones push a delta.
    always_comb begin
        state_nxt_s = state_r;
        prev_nxt_s  = prev_r;
        push_s      = 1'b0;
        if (i_clear) begin
            state_nxt_s = ST_UNPRIMED;
        end else begin
            case (state_r)
                ST_UNPRIMED: begin
                    if (accept_s) begin
                        prev_nxt_s  = i_acc;
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_UNPRIMED;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        push_s     = 1'b1;
                        prev_nxt_s = i_acc;
                    end else begin
                        push_s     = 1'b0;
                    end
                end
                default: begin
                    state_nxt_s = ST_UNPRIMED;
                end
            endcase
        end
    end

    // State and reference-value registers.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_r <= ST_UNPRIMED;
            prev_r  <= {BUS_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            prev_r  <= prev_nxt_s;
        end
    end

    // FIFO pointers and occupancy; clear flushes without touching storage.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else if (i_clear) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {BUS_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= delta_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

endmodule

// File: tb/tb_acc_delta_decoder.sv
// Self-checking bench for acc_delta_decoder: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_acc_delta_decoder;

    localparam int W     = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_clear = 1'b0;
    logic         i_valid = 1'b0;
    logic [W-1:0] i_acc = 4'd0;
    logic         i_ready = 1'b0;
    logic         o_ready;
    logic         o_valid;
    logic [W-1:0] o_delta;
    logic         o_primed;
    logic [2:0]   o_count;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: a queue of pending deltas plus the last accepted sample.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_prev = 4'd0;
    logic         m_primed = 1'b0;

    acc_delta_decoder #(.BUS_WIDTH(W), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_arst_n(rst_n), .i_clear(i_clear), .i_valid(i_valid),
        .i_acc(i_acc), .o_ready(o_ready), .o_valid(o_valid), .o_delta(o_delta),
        .i_ready(i_ready), .o_primed(o_primed), .o_count(o_count)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] exp_vec();
        logic [W-1:0] d;
        d = (m_q.size() != 0) ? m_q[0] : 4'd0;
        return {m_q.size() != 0, m_q.size() < DEPTH, m_primed, 3'(m_q.size()), d};
    endfunction

    function automatic logic [9:0] act_vec();
        return {o_valid, o_ready, o_primed, o_count, o_delta};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_primed = 1'b0;
        m_prev   = 4'd0;
    endtask

    // Apply the current inputs to the model, advance one clock, settle 1 time unit.
    task automatic tick();
        int sz;
        sz = m_q.size();
        if (i_clear) begin
            m_q.delete();
            m_primed = 1'b0;
        end else begin
            if (sz > 0 && i_ready) void'(m_q.pop_front());
            if (i_valid && sz < DEPTH) begin
                if (m_primed) m_q.push_back(4'(i_acc - m_prev));
                m_primed = 1'b1;
                m_prev   = i_acc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        i_valid = 1'b0;
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    task automatic test_reset();
        i_valid = 1'b1;
        i_acc   = 4'd9;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({o_valid, o_primed, o_count, o_ready, o_delta} !== {1'b0, 1'b0, 3'd0, 1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b p=%b c=%0d r=%b d=%0d, want v=0 p=0 c=0 r=1 d=0",
                     o_valid, o_primed, o_count, o_ready, o_delta);
        end
        i_valid = 1'b0;
        rst_n   = 1'b1;
        model_reset();
        tick();
        tests_run++;
        if (o_primed !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_no_accept: o_primed=%b, want 0", o_primed);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] seq [3] = '{4'd3, 4'd5, 4'd12};
        logic [9:0]   want [3];
        want[0] = {1'b0, 1'b1, 1'b1, 3'd0, 4'd0};
        want[1] = {1'b1, 1'b1, 1'b1, 3'd1, 4'd2};
        want[2] = {1'b1, 1'b1, 1'b1, 3'd1, 4'd7};
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_acc   = seq[k];
            tick();
            tests_run++;
            if (act_vec() !== want[k] || act_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL basic_step%0d: got %b, want %b (model %b)", k, act_vec(), want[k], exp_vec());
            end
        end
        i_valid = 1'b0;
        tick();
        tests_run++;
        if (o_valid !== 1'b0 || o_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL basic_drain: v=%b c=%0d, want v=0 c=0", o_valid, o_count);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] seq [3] = '{4'd14, 4'd1, 4'd1};
        logic [W-1:0] want_d [3] = '{4'd0, 4'd3, 4'd0};
        logic         want_v [3] = '{1'b0, 1'b1, 1'b1};
        do_clear();
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_acc   = seq[k];
            tick();
            tests_run++;
            if (o_valid !== want_v[k] || o_delta !== want_d[k] || act_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL wrap_step%0d: got v=%b d=%0d, want v=%b d=%0d", k, o_valid, o_delta, want_v[k], want_d[k]);
            end
        end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] seq [5] = '{4'd0, 4'd1, 4'd3, 4'd6, 4'd10};
        logic [W-1:0] want_d [5] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
        logic [2:0]   want_c [5] = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        do_clear();
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_acc   = seq[k];
            tick();
        end
        i_acc = 4'd15;
        tick();
        tests_run++;
        if (o_count !== 3'd4 || o_ready !== 1'b0 || o_delta !== 4'd1 || act_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL bp_full: c=%0d r=%b d=%0d, want c=4 r=0 d=1", o_count, o_ready, o_delta);
        end
        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) i_valid = 1'b0;
            tick();
            tests_run++;
            if (o_delta !== want_d[k] || o_count !== want_c[k] || act_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL bp_drain%0d: d=%0d c=%0d, want d=%0d c=%0d", k, o_delta, o_count, want_d[k], want_c[k]);
            end
        end
    endtask

    task automatic test_clear();
        do_clear();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_acc = 4'd1; tick();
        i_acc = 4'd3; tick();
        i_acc = 4'd6; tick();
        i_clear = 1'b1;
        i_acc   = 4'd7;
        tick();
        i_clear = 1'b0;
        tests_run++;
        if (o_valid !== 1'b0 || o_primed !== 1'b0 || o_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL clear_flush: v=%b p=%b c=%0d, want 0 0 0", o_valid, o_primed, o_count);
        end
        i_acc = 4'd8;
        tick();
        tests_run++;
        if (o_primed !== 1'b1 || o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_reprime: p=%b v=%b, want p=1 v=0", o_primed, o_valid);
        end
        i_ready = 1'b1;
        i_acc   = 4'd9;
        tick();
        i_valid = 1'b0;
        tests_run++;
        if (o_delta !== 4'd1 || act_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL clear_ref: d=%0d, want 1", o_delta);
        end
        tick();
    endtask

    task automatic test_async_reset();
        do_clear();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_acc = 4'd2; tick();
        i_acc = 4'd3; tick();
        i_acc = 4'd5; tick();
        i_acc = 4'd9; tick();
        i_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (o_valid !== 1'b0 || o_count !== 3'd0 || o_primed !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: v=%b c=%0d p=%b, want 0 0 0", o_valid, o_count, o_primed);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_acc   = 4'd4;
        tick();
        tests_run++;
        if (o_primed !== 1'b1 || o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reprime: p=%b v=%b, want p=1 v=0", o_primed, o_valid);
        end
        i_acc = 4'd6;
        tick();
        i_valid = 1'b0;
        tests_run++;
        if (o_delta !== 4'd2 || o_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_delta: d=%0d v=%b, want d=2 v=1", o_delta, o_valid);
        end
        tick();
    endtask

    task automatic test_random();
        do_clear();
        for (int n = 0; n < 400; n++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_acc   = 4'($urandom_range(0, 15));
            i_ready = ($urandom_range(0, 2) != 0) || (n % 64 < 20 && n % 64 > 10) ? ($urandom_range(0, 3) == 0) : 1'b1;
            i_clear = ($urandom_range(0, 49) == 0);
            tick();
            tests_run++;
            if (act_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random_cycle%0d: got v/r/p/c/d=%b, want %b", n, act_vec(), exp_vec());
            end
        end
        i_clear = 1'b0;
        i_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/acc_delta_decoder.md
Name: acc_delta_decoder

Overview:
- Inverse of the running-sum accumulator. Consumes a stream of wrapped accumulator values and recovers the per-step increments as modulo-2^BUS_WIDTH differences.
- Accepted values arrive on a valid/ready input handshake. Recovered deltas are buffered in a small FIFO and presented on a valid/ready output handshake.
- Sits downstream of an accumulator in the same clock domain and checks or reconstructs its input sequence.

Parameters:
- BUS_WIDTH, 4, width of accumulator values and recovered deltas.
- DEPTH, 4, output FIFO entries; power of two, minimum 2.

Ports:
- i_clk  input  1  clock; all state updates on posedge.
- i_arst_n  input  1  asynchronous active-low reset.
- i_clear  input  1  synchronous clear: flush FIFO, return to UNPRIMED.
- i_valid  input  1  i_acc holds a valid accumulator value.
- i_acc  input  BUS_WIDTH  accumulator value.
- o_ready  output  1  block can accept i_acc this cycle.
- o_valid  output  1  o_delta holds a valid recovered increment.
- o_delta  output  BUS_WIDTH  recovered increment (FIFO head).
- i_ready  input  1  downstream accepts o_delta this cycle.
- o_primed  output  1  a reference value is held (state RUN).
- o_count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (i_arst_n=0, asynchronous):
  - state=UNPRIMED, prev=0, FIFO empty (count=0, pointers=0).
  - Outputs: o_valid=0, o_primed=0, o_count=0, o_delta=0, o_ready=1.
- Input handshake:
  - Accept = i_valid & o_ready.
  - o_ready = (o_count < DEPTH), combinational from the registered count.
  - A pop in the same cycle does not raise o_ready while full.
- State machine (two states):
  - UNPRIMED: on accept, prev<=i_acc, go to RUN. Nothing is pushed.
  - RUN: on accept, push (i_acc - prev) mod 2^BUS_WIDTH, then prev<=i_acc.
  - Subtraction is plain BUS_WIDTH-bit two's-complement wrap, with no carry or sign output. Example: 1-14 gives 3 for W=4.
- Output handshake:
  - o_valid = (o_count != 0); o_delta = FIFO entry at the read pointer.
  - Pop = o_valid & i_ready.
  - o_delta must stay stable while o_valid=1 and i_ready=0.
  - o_delta is 0 when empty: the read pointer location is not required to be 0; drive 0 when count==0.
- Latency:
  - A delta accepted at edge N is visible with o_valid=1 after edge N, so the consumer can take it in the next cycle.
  - No bypass: push and pop in the same cycle with count==0 is impossible.
- Simultaneous push and pop (0<count<DEPTH): count unchanged; both pointers advance.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Order strictly FIFO.
- i_clear:
  - Highest priority after reset. On the clear edge: state=UNPRIMED, FIFO flushed (count=0), prev unchanged-don't-care.
  - Any input accept or pop in that same cycle is discarded.
  - o_valid=0 from the next cycle. The next accepted sample primes.
- Reset mid-operation: all buffered deltas are lost and the reference is dropped. The first post-reset sample primes.
- i_valid while UNPRIMED with a non-empty FIFO cannot occur, because clear and reset both flush the FIFO.

Test Plan:
- Reset with i_valid=1, i_acc=9 held during reset -> o_valid=0, o_primed=0, o_count=0, o_ready=1. Nothing is accepted until release.
- Accept 3, 5, 12 with i_ready=1 -> first sample raises o_primed with no output. Deltas 2 and 7 appear one cycle after their accepts.
- Wrap: prime 14, then accept 1, then 1 -> deltas 3, then 0.
- Backpressure: i_ready=0, prime 0, then offer 1, 3, 6, 10, 15 -> four deltas accepted (1, 2, 3, 4). o_ready=0 with o_count=4, and value 15 is held off. Raise i_ready -> out 1, 2, 3, 4; 15 is then accepted giving delta 5; order preserved.
- Clear mid-stream: 2 deltas buffered, pulse i_clear with i_valid=1 (value 7) -> 7 is not accepted, o_valid=0 next cycle, o_primed=0. The next sample 8 primes with no output.
- Async reset asserted between clock edges with 3 deltas buffered -> o_valid and o_count drop immediately, without waiting for a clock edge. After release, the next sample primes.
